// File: rtl/mips_defs_pkg.sv
// Shared definitions for the MIPS-style front end: reset vector,
// instruction field positions, NOP encoding and fetch FSM states.
`timescale 1ns/1ps
package mips_defs;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {
    FETCH = 1'b0,
    WAIT  = 1'b1
  } fetch_state_e;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Pure combinational split of a 32-bit instruction word into its fields.
// Shared by the fetch stage and the later decode stages.
`timescale 1ns/1ps
module instr_field_split
  import mips_defs::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
  assign rs     = instr[RS_MSB:RS_LSB];
  assign rt     = instr[RT_MSB:RT_LSB];
  assign rd     = instr[RD_MSB:RD_LSB];
  assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
  assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
  assign imm16  = instr[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, issues one outstanding word
// request at a time, holds the returned word in a stallable output slot
// and supports redirect with flush of an in-flight response.
`timescale 1ns/1ps
module inst_fetch
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         drop_q, drop_d;
  logic         out_valid_q, out_valid_d;
  logic [31:0]  out_pc_q, out_pc_d;
  logic [31:0]  out_instr_q, out_instr_d;
  logic         req_int;
  logic         unused_addr_bits;

  assign unused_addr_bits = ^redirect_pc[1:0];

  // A request may only go out when the slot is free or draining this cycle,
  // so a returning word can never overwrite an unconsumed instruction.
  always_comb begin
    req_int = (state_q == FETCH) && (!out_valid_q || !stall) && !redirect && !rst;
  end

  // Next-state logic: redirect wins over stall and rvalid; a flushed
  // request is tracked with drop until its response comes back.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;

    if (out_valid_q && !stall) begin
      out_valid_d = 1'b0;
    end

    if (redirect) begin
      pc_d        = word_align(redirect_pc);
      out_valid_d = 1'b0;
    end

    case (state_q)
      FETCH: begin
        if (req_int && imem_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + 32'd4;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = FETCH;
          drop_d  = 1'b0;
          if (!redirect && !drop_q) begin
            out_pc_d    = req_pc_q;
            out_instr_d = imem_rdata;
            out_valid_d = 1'b1;
          end
        end else if (redirect) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // State registers with asynchronous reset to the reset vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      req_pc_q    <= 32'd0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 32'd0;
      out_instr_q <= NOP_WORD;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end

  assign imem_req  = req_int;
  assign imem_addr = pc_q;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  instr_field_split u_split (
    .instr  (out_instr_q),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed, scoreboard-checked bench for the instruction fetch stage.
`timescale 1ns/1ps
module tb_inst_fetch;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic prevValid = 1'b0;
  logic prevStall = 1'b0;

  inst_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .shamt       (shamt),
    .funct       (funct),
    .imm16       (imm16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Wait for a request at expAddr, accept it, then return data rvDelay
  // cycles later; deliverable words are pushed onto the scoreboard.
  task automatic applyStimulus(input logic [31:0] expAddr, input logic [31:0] data,
                               input int rvDelay, input bit deliver);
    int waited;
    waited = 0;
    #1;
    while (!imem_req && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("request seen", {31'd0, imem_req}, 32'd1);
    checkOutput("imem_addr", imem_addr, expAddr);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int i = 1; i < rvDelay; i++) tick();
    imem_rvalid = 1'b1;
    imem_rdata  = data;
    if (deliver) expQ.push_back('{pc: expAddr, instr: data});
    tick();
    imem_rvalid = 1'b0;
    if (deliver) checkOutput("out_valid latency", {31'd0, out_valid}, 32'd1);
  endtask

  // Monitor: every freshly loaded slot must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst) begin
      prevValid = 1'b0;
      prevStall = 1'b0;
    end else begin
      if (out_valid && (!prevValid || !prevStall)) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL unexpected output: pc %h instr %h, expected none", out_pc, out_instr);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("out_pc", out_pc, e.pc);
          checkOutput("out_instr", out_instr, e.instr);
          checkOutput("opcode", {26'd0, opcode}, {26'd0, e.instr[31:26]});
          checkOutput("funct", {26'd0, funct}, {26'd0, e.instr[5:0]});
          checkOutput("imm16", {16'd0, imm16}, {16'd0, e.instr[15:0]});
        end
      end
      prevValid = out_valid;
      prevStall = stall;
    end
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_pc", out_pc, 32'd0);
    checkOutput("reset out_instr", out_instr, 32'd0);
    checkOutput("reset imem_addr", imem_addr, 32'h0000_3000);
    rst = 1'b0;

    // First fetch and field split of add $8,$9,$10.
    applyStimulus(32'h0000_3000, 32'h012A_4020, 1, 1'b1);
    checkOutput("add opcode", {26'd0, opcode}, 32'd0);
    checkOutput("add rs", {27'd0, rs}, 32'd9);
    checkOutput("add rt", {27'd0, rt}, 32'd10);
    checkOutput("add rd", {27'd0, rd}, 32'd8);
    checkOutput("add shamt", {27'd0, shamt}, 32'd0);
    checkOutput("add funct", {26'd0, funct}, 32'h20);
    checkOutput("add imm16", {16'd0, imm16}, 32'h4020);
    checkOutput("next addr", imem_addr, 32'h0000_3004);
    checkOutput("next req", {31'd0, imem_req}, 32'd1);

    // Stall holds the slot and blocks further requests.
    stall = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall imem_req", {31'd0, imem_req}, 32'd0);
      checkOutput("stall out_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("stall out_pc", out_pc, 32'h0000_3000);
      checkOutput("stall out_instr", out_instr, 32'h012A_4020);
      tick();
    end
    stall = 1'b0;
    #1;
    checkOutput("unstall imem_req", {31'd0, imem_req}, 32'd1);
    applyStimulus(32'h0000_3004, 32'h8D2A_0004, 1, 1'b1);

    // Redirect while waiting: late data must be dropped.
    #1;
    checkOutput("pre-redirect addr", imem_addr, 32'h0000_3008);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_4003;
    tick();
    redirect = 1'b0;
    checkOutput("drop out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("drop imem_req", {31'd0, imem_req}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0;
    #1;
    checkOutput("dropped out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("redirect req", {31'd0, imem_req}, 32'd1);
    checkOutput("redirect addr", imem_addr, 32'h0000_4000);
    applyStimulus(32'h0000_4000, 32'h3C01_1234, 2, 1'b1);

    // Redirect and rvalid in the same cycle.
    #1;
    checkOutput("pre-same addr", imem_addr, 32'h0000_4004);
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h0000_5000;
    imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    tick();
    redirect = 1'b0; imem_rvalid = 1'b0;
    #1;
    checkOutput("same-cycle out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("same-cycle req", {31'd0, imem_req}, 32'd1);
    checkOutput("same-cycle addr", imem_addr, 32'h0000_5000);
    applyStimulus(32'h0000_5000, 32'h2108_FFFF, 1, 1'b1);
    checkOutput("after target addr", imem_addr, 32'h0000_5004);

    // Redirect in FETCH to the top word, then wrap to zero.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    #1;
    checkOutput("fetch redirect req", {31'd0, imem_req}, 32'd0);
    tick();
    redirect = 1'b0;
    #1;
    checkOutput("fetch redirect out_valid", {31'd0, out_valid}, 32'd0);
    applyStimulus(32'hFFFF_FFFC, 32'h0800_0C00, 1, 1'b1);
    checkOutput("wrap addr", imem_addr, 32'h0000_0000);

    // Reset in the middle of an outstanding request.
    #1;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("mid-reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mid-reset imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("mid-reset out_pc", out_pc, 32'd0);
    checkOutput("mid-reset pc", imem_addr, 32'h0000_3000);
    tick();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'hFEED_FACE;
    tick();
    imem_rvalid = 1'b0;
    #1;
    checkOutput("stale out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("stale addr", imem_addr, 32'h0000_3000);
    checkOutput("stale req", {31'd0, imem_req}, 32'd1);
    applyStimulus(32'h0000_3000, 32'h0000_0000, 1, 1'b1);

    repeat (3) tick();
    checkOutput("scoreboard drained", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
